// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder-side and position-side signal bundle for quad_decoder
// Ports (via modports):
//   master: drives a_in, b_in, syn_clr, load, d; observes step, dir, err, pos, max_tick, min_tick
//   slave : the decoder itself, the mirror image of master
interface quad_decoder_if #(
    parameter int N = 8
);
    logic         a_in;
    logic         b_in;
    logic         syn_clr;
    logic         load;
    logic [N-1:0] d;
    logic         step;
    logic         dir;
    logic         err;
    logic [N-1:0] pos;
    logic         max_tick;
    logic         min_tick;

    modport master (
        output a_in, b_in, syn_clr, load, d,
        input  step, dir, err, pos, max_tick, min_tick
    );

    modport slave (
        input  a_in, b_in, syn_clr, load, d,
        output step, dir, err, pos, max_tick, min_tick
    );
endinterface

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - 4x quadrature decoder with wrapping loadable position count
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : quad_decoder_if.slave
//           a_in/b_in async encoder phases, syn_clr/load/d position control,
//           step/dir/err decode events, pos count, max_tick/min_tick terminal flags
module quad_decoder #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          reset,
    quad_decoder_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t       state_q, state_d;
    logic [1:0]   init_cnt_q, init_cnt_d;
    logic         a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic         b_s1_q, b_s1_d, b_s2_q, b_s2_d;
    logic [1:0]   prev_q, prev_d;
    logic         step_q, step_d;
    logic         dir_q, dir_d;
    logic         err_q, err_d;
    logic [N-1:0] pos_q, pos_d;

    logic [1:0]   ab_cur;
    logic [1:0]   delta;
    logic         fwd, rev, ill;

    // Map the Gray-coded phase pair onto its position in the forward cycle
    // 00 -> 10 -> 11 -> 01, so a forward step is always +1 modulo 4.
    function automatic logic [1:0] phase_idx(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;

        a_s1_d = bus.a_in;
        a_s2_d = a_s1_q;
        b_s1_d = bus.b_in;
        b_s2_d = b_s1_q;

        ab_cur = {a_s2_q, b_s2_q};
        prev_d = ab_cur;

        // delta: 0 none, 1 forward, 3 reverse, 2 both phases flipped.
        delta = phase_idx(ab_cur) - phase_idx(prev_q);
        fwd   = (state_q == RUN) && (delta == 2'd1);
        rev   = (state_q == RUN) && (delta == 2'd3);
        ill   = (state_q == RUN) && (delta == 2'd2);

        // Two full clocks after release fill s1/s2; prev then loads a valid
        // sample on the edge that enters RUN, so a static encoder never
        // produces a spurious event.
        if (state_q == INIT) begin
            if (init_cnt_q == 2'd2) begin
                state_d = RUN;
            end else begin
                init_cnt_d = init_cnt_q + 2'd1;
            end
        end

        step_d = fwd | rev;

        dir_d = dir_q;
        if (fwd) begin
            dir_d = 1'b1;
        end else if (rev) begin
            dir_d = 1'b0;
        end

        // An illegal transition in the same cycle as syn_clr leaves err set.
        err_d = err_q;
        if (ill) begin
            err_d = 1'b1;
        end else if (bus.syn_clr) begin
            err_d = 1'b0;
        end

        pos_d = pos_q;
        if (bus.syn_clr) begin
            pos_d = '0;
        end else if (bus.load) begin
            pos_d = bus.d;
        end else if (fwd) begin
            pos_d = pos_q + N'(1);
        end else if (rev) begin
            pos_d = pos_q - N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= INIT;
            init_cnt_q <= 2'd0;
            a_s1_q     <= 1'b0;
            a_s2_q     <= 1'b0;
            b_s1_q     <= 1'b0;
            b_s2_q     <= 1'b0;
            prev_q     <= 2'b00;
            step_q     <= 1'b0;
            dir_q      <= 1'b1;
            err_q      <= 1'b0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            a_s1_q     <= a_s1_d;
            a_s2_q     <= a_s2_d;
            b_s1_q     <= b_s1_d;
            b_s2_q     <= b_s2_d;
            prev_q     <= prev_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
        end
    end

    assign bus.step     = step_q;
    assign bus.dir      = dir_q;
    assign bus.err      = err_q;
    assign bus.pos      = pos_q;
    assign bus.max_tick = &pos_q;
    assign bus.min_tick = ~|pos_q;
endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder
module tb_quad_decoder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;

    quad_decoder_if #(.N(8)) bus ();

    quad_decoder #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ab(input logic a, input logic b);
        bus.a_in = a;
        bus.b_in = b;
    endtask

    task automatic pulse_clr;
        bus.syn_clr = 1'b1;
        cyc(1);
        bus.syn_clr = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_err       = 0;
        reset       = 1'b0;
        bus.a_in    = 1'b1;
        bus.b_in    = 1'b1;
        bus.syn_clr = 1'b0;
        bus.load    = 1'b0;
        bus.d       = 8'h00;

        // Reset with encoder parked at 11
        cyc(3);
        chk("rst_pos",  32'(bus.pos), 32'd0);
        chk("rst_step", 32'(bus.step), 32'd0);
        chk("rst_dir",  32'(bus.dir), 32'd1);
        chk("rst_err",  32'(bus.err), 32'd0);
        chk("rst_min",  32'(bus.min_tick), 32'd1);
        chk("rst_max",  32'(bus.max_tick), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("init_step", 32'(bus.step), 32'd0);
            chk("init_err",  32'(bus.err), 32'd0);
        end
        chk("init_pos", 32'(bus.pos), 32'd0);
        chk("init_min", 32'(bus.min_tick), 32'd1);

        // Walk 11 -> 01 -> 00 (two forward steps), then clear
        set_ab(1'b0, 1'b1);
        cyc(4);
        chk("pre_pos1", 32'(bus.pos), 32'd1);
        set_ab(1'b0, 1'b0);
        cyc(4);
        chk("pre_pos2", 32'(bus.pos), 32'd2);
        pulse_clr();
        chk("pre_clr", 32'(bus.pos), 32'd0);

        // Forward 00 -> 10 -> 11 -> 01 -> 00, step exactly 3 edges after drive
        set_ab(1'b1, 1'b0);
        cyc(2); chk("fwd1_early", 32'(bus.step), 32'd0);
        cyc(1); chk("fwd1_step", 32'(bus.step), 32'd1); chk("fwd1_dir", 32'(bus.dir), 32'd1);
        cyc(1); chk("fwd1_single", 32'(bus.step), 32'd0);
        set_ab(1'b1, 1'b1);
        cyc(2); chk("fwd2_early", 32'(bus.step), 32'd0);
        cyc(1); chk("fwd2_step", 32'(bus.step), 32'd1);
        cyc(1); chk("fwd2_single", 32'(bus.step), 32'd0);
        set_ab(1'b0, 1'b1);
        cyc(2); chk("fwd3_early", 32'(bus.step), 32'd0);
        cyc(1); chk("fwd3_step", 32'(bus.step), 32'd1);
        cyc(1); chk("fwd3_single", 32'(bus.step), 32'd0);
        set_ab(1'b0, 1'b0);
        cyc(2); chk("fwd4_early", 32'(bus.step), 32'd0);
        cyc(1); chk("fwd4_step", 32'(bus.step), 32'd1);
        cyc(1); chk("fwd4_single", 32'(bus.step), 32'd0);
        chk("fwd_pos", 32'(bus.pos), 32'd4);
        chk("fwd_dir", 32'(bus.dir), 32'd1);

        // Reverse wrap from 0
        pulse_clr();
        chk("rev_clr", 32'(bus.pos), 32'd0);
        set_ab(1'b0, 1'b1);
        cyc(3);
        chk("rev_step", 32'(bus.step), 32'd1);
        chk("rev_dir",  32'(bus.dir), 32'd0);
        chk("rev_pos",  32'(bus.pos), 32'd255);
        chk("rev_max",  32'(bus.max_tick), 32'd1);
        chk("rev_min",  32'(bus.min_tick), 32'd0);
        cyc(1);
        set_ab(1'b0, 1'b0);
        cyc(3);
        chk("wrap_pos", 32'(bus.pos), 32'd0);
        chk("wrap_min", 32'(bus.min_tick), 32'd1);
        chk("wrap_dir", 32'(bus.dir), 32'd1);
        cyc(1);

        // Illegal 00 -> 11 from a loaded position
        bus.load = 1'b1;
        bus.d    = 8'd7;
        cyc(1);
        bus.load = 1'b0;
        chk("ld_pos", 32'(bus.pos), 32'd7);
        set_ab(1'b1, 1'b1);
        cyc(3);
        chk("ill_err",  32'(bus.err), 32'd1);
        chk("ill_step", 32'(bus.step), 32'd0);
        chk("ill_pos",  32'(bus.pos), 32'd7);
        chk("ill_dir",  32'(bus.dir), 32'd1);
        cyc(1);
        pulse_clr();
        chk("clr_err", 32'(bus.err), 32'd0);
        chk("clr_pos", 32'(bus.pos), 32'd0);

        // Illegal 11 -> 00 decoded on the same edge as syn_clr: set wins
        set_ab(1'b0, 1'b0);
        cyc(2);
        bus.syn_clr = 1'b1;
        cyc(1);
        bus.syn_clr = 1'b0;
        chk("ill_clr_err",  32'(bus.err), 32'd1);
        chk("ill_clr_pos",  32'(bus.pos), 32'd0);
        chk("ill_clr_step", 32'(bus.step), 32'd0);
        cyc(1);

        // Load overrides a forward step; step/dir still reported
        bus.load = 1'b1;
        bus.d    = 8'd10;
        cyc(1);
        bus.load = 1'b0;
        chk("ld10_pos", 32'(bus.pos), 32'd10);
        set_ab(1'b1, 1'b0);
        cyc(2);
        bus.load = 1'b1;
        bus.d    = 8'hA5;
        cyc(1);
        bus.load = 1'b0;
        chk("ldstep_pos",  32'(bus.pos), 32'hA5);
        chk("ldstep_step", 32'(bus.step), 32'd1);
        chk("ldstep_dir",  32'(bus.dir), 32'd1);
        chk("ldstep_err",  32'(bus.err), 32'd1);
        cyc(1);
        bus.syn_clr = 1'b1;
        bus.load    = 1'b1;
        bus.d       = 8'h33;
        cyc(1);
        bus.syn_clr = 1'b0;
        bus.load    = 1'b0;
        chk("clrld_pos", 32'(bus.pos), 32'd0);
        chk("clrld_err", 32'(bus.err), 32'd0);

        // Forward to pos=3, then a one-cycle reset mid-step
        set_ab(1'b1, 1'b1);
        cyc(4);
        set_ab(1'b0, 1'b1);
        cyc(4);
        set_ab(1'b0, 1'b0);
        cyc(4);
        chk("mid_pos3", 32'(bus.pos), 32'd3);
        set_ab(1'b1, 1'b0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("mid_rst_pos",  32'(bus.pos), 32'd0);
        chk("mid_rst_step", 32'(bus.step), 32'd0);
        chk("mid_rst_dir",  32'(bus.dir), 32'd1);
        chk("mid_rst_err",  32'(bus.err), 32'd0);
        chk("mid_rst_min",  32'(bus.min_tick), 32'd1);
        chk("mid_rst_max",  32'(bus.max_tick), 32'd0);
        reset = 1'b1;
        set_ab(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("mid_init_step", 32'(bus.step), 32'd0);
            chk("mid_init_err",  32'(bus.err), 32'd0);
        end
        chk("mid_init_pos", 32'(bus.pos), 32'd0);
        set_ab(1'b0, 1'b1);
        cyc(3);
        chk("resume_step", 32'(bus.step), 32'd1);
        chk("resume_pos",  32'(bus.pos), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
